seq_detect_scheduler: RTL and testbench
=======================================

SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 8, giving the serial frame length in bits (MSB first).
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of hit_count.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port nRST, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req, input, 2 bits: per-requester frame request, level-sensitive.
REQ-006 SHALL have port data0, input, FRAME_BITS bits: frame from requester 0.
REQ-007 SHALL have port data1, input, FRAME_BITS bits: frame from requester 1.
REQ-008 SHALL have port gnt, output, 2 bits: one-hot grant, one-cycle pulse.
REQ-009 SHALL have port det_X, output, 1 bit: serial bit to the shared SequenceDetector X.
REQ-010 SHALL have port det_nRST, output, 1 bit: drives the detector's nRST.
REQ-011 SHALL have port det_Y, input, 1 bit: the detector's Y output.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 SHALL have port done_id, output, 1 bit: index of the requester whose frame completed; valid with done.
REQ-015 SHALL have port hit_count, output, CNT_W bits: number of det_Y=1 samples in the frame; valid with done.

Function
REQ-016 SHALL implement an FSM with states IDLE, GRANT, CLRDET, SHIFT, DRAIN and DONE.
REQ-017 IDLE: on any req bit high, SHALL select a winner, latch its data into the shift register, and go to GRANT; otherwise stay in IDLE.
REQ-018 GRANT: SHALL assert gnt[winner] for exactly one cycle, clear the hit counter, and go to CLRDET.
REQ-019 CLRDET: SHALL drive det_nRST=0 for exactly one cycle, then go to SHIFT; det_nRST SHALL be 1 in all other states.
REQ-020 SHALL drive det_X in SHIFT for FRAME_BITS cycles, with bit FRAME_BITS-1-i in SHIFT cycle i, then go to DRAIN; det_X SHALL be 0 in all other states.
REQ-021 SHALL sample det_Y in SHIFT cycles 1..FRAME_BITS-1 and in DRAIN (FRAME_BITS samples total), incrementing the counter on each 1.
REQ-022 The hit counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-023 DONE: SHALL assert done for one cycle with done_id and hit_count stable, then go to IDLE.
REQ-024 hit_count and done_id SHALL hold their values until the next GRANT.
REQ-025 Latency: done SHALL be high in the cycle FRAME_BITS+3 edges after the IDLE edge that sampled req (11 edges for the default).
REQ-026 Changes to req or data during a frame SHALL be ignored, because frame data is latched at selection.
REQ-027 A requester SHALL be served again only if its req is still high when the FSM next returns to IDLE.
REQ-028 Back-to-back frames SHALL be supported, with at most one IDLE cycle between DONE and the next GRANT.

Reset
REQ-029 While nRST=0 at a clock edge, the FSM SHALL go to IDLE and the RR pointer SHALL go to 0.
REQ-030 While nRST=0, outputs SHALL be gnt=0, det_X=0, busy=0, done=0, done_id=0 and hit_count=0.
REQ-031 det_nRST SHALL follow nRST (0) during reset, so the detector is reset with the block.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; service SHALL resume normally after reset releases.

Configuration
REQ-033 With macro SEQ_SCHED_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins, and the pointer updates at GRANT.
REQ-034 Without SEQ_SCHED_RR_EN, arbitration SHALL be fixed priority with req[0] always winning; no pointer register SHALL exist.

Verification
REQ-035 Single frame: req=01, data0=8'b1011_0110, bench holds det_Y=0 -> gnt=01, det_X shows 1,0,1,1,0,1,1,0, done after 11 edges, hit_count=0, done_id=0.
REQ-036 Hit counting: as REQ-035 but det_Y=1 on samples 3 and 6 -> hit_count=2; then det_Y=1 on all 8 samples -> hit_count=8.
REQ-037 Saturation: CNT_W=2, det_Y=1 on all samples -> hit_count=3.
REQ-038 Contention: req=11 held for 3 frames -> RR_EN gives done_id 0,1,0; no macro gives done_id 0,0,0.
REQ-039 Reset: nRST=0 in SHIFT cycle 4 -> next edge gives busy=0, det_X=0 and det_nRST=0, no done pulse; after release a new frame completes correctly.
REQ-040 Detector clear: det_nRST=0 for exactly one cycle per frame, in the cycle after gnt.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// Two-requester serial frame scheduler driving a shared sequence detector.
// Define SEQ_SCHED_RR_EN for round-robin arbitration; default is fixed priority (req[0] wins).
module seq_detect_scheduler #(
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [1:0]            req,
    input  logic [FRAME_BITS-1:0] data0,
    input  logic [FRAME_BITS-1:0] data1,
    output logic [1:0]            gnt,
    output logic                  det_X,
    output logic                  det_nRST,
    input  logic                  det_Y,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [CNT_W-1:0]      hit_count
);

    localparam int unsigned IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StClrDet,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        hits_q;
    logic                    win_q;
    logic                    done_id_q;
    logic                    sel;
    logic                    hit_inc;

`ifdef SEQ_SCHED_RR_EN
    logic ptr_q;

    // ptr_q names the requester that has priority on a tie
    always_comb begin
        sel = 1'b0;
        if (req[0] && req[1]) begin
            sel = ptr_q;
        end else begin
            sel = req[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr_q <= 1'b0;
        end else if (state_q == StGrant) begin
            ptr_q <= ~win_q;
        end
    end
`else
    assign sel = ~req[0];
`endif

    // First SHIFT cycle has no valid detector output yet; DRAIN supplies the last sample
    assign hit_inc = det_Y && (hits_q != {CNT_W{1'b1}}) &&
                     (((state_q == StShift) && (idx_q != '0)) || (state_q == StDrain));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            idx_q     <= '0;
            hits_q    <= '0;
            win_q     <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hit_inc) begin
                hits_q <= hits_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        win_q   <= sel;
                        shreg_q <= sel ? data1 : data0;
                    end
                end
                StGrant: begin
                    hits_q    <= '0;
                    done_id_q <= win_q;
                end
                StClrDet: begin
                    idx_q <= '0;
                end
                StShift: begin
                    shreg_q <= shreg_q << 1;
                    idx_q   <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt      = 2'b00;
        det_X    = 1'b0;
        det_nRST = nRST;
        busy     = (state_q != StIdle);
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt     = win_q ? 2'b10 : 2'b01;
                state_d = StClrDet;
            end
            StClrDet: begin
                det_nRST = 1'b0;
                state_d  = StShift;
            end
            StShift: begin
                det_X = shreg_q[FRAME_BITS-1];
                if (idx_q == LAST_IDX) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Outputs are quiet for the whole reset interval, not just after the first edge
        if (!nRST) begin
            gnt   = 2'b00;
            det_X = 1'b0;
            busy  = 1'b0;
            done  = 1'b0;
        end
    end

    assign done_id   = nRST ? done_id_q : 1'b0;
    assign hit_count = nRST ? hits_q : '0;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: stimulus pushes expected frames, a negedge
// monitor models the detector's Y output and checks each done against the queue head.
module tb_seq_detect_scheduler;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       det_Y = 1'b0;

    logic [1:0] gnt, gnt2;
    logic       det_X, det_X2, det_nRST, det_nRST2;
    logic       busy, busy2, done, done2, done_id, done_id2;
    logic [3:0] hit_count;
    logic [1:0] hit_count2;

    always #5 CLK = ~CLK;

    seq_detect_scheduler #(.FRAME_BITS(8), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .det_X(det_X), .det_nRST(det_nRST), .det_Y(det_Y),
        .busy(busy), .done(done), .done_id(done_id), .hit_count(hit_count)
    );

    seq_detect_scheduler #(.FRAME_BITS(8), .CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt2), .det_X(det_X2), .det_nRST(det_nRST2), .det_Y(det_Y),
        .busy(busy2), .done(done2), .done_id(done_id2), .hit_count(hit_count2)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [8:0] mask;   // bit j: det_Y=1 during frame cycle j (0..7 shift, 8 drain)
        int         hits;
    } item_t;

    item_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor and detector model
    int         cyc = 0;
    int         gnt_cyc = -100;
    int         clr_cyc = -100;
    int         clr_n = 0;
    int         j;
    bit         in_frame = 0;
    logic [7:0] xs = '0;
    item_t      it;

    always @(negedge CLK) begin
        cyc++;
        if (!nRST) begin
            in_frame = 0;
            clr_n    = 0;
            det_Y    = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                chk("gnt_onehot", (gnt == 2'b01) || (gnt == 2'b10), 1);
                chk("busy_in_grant", busy, 1);
                if (q.size() > 0) chk("gnt_id", gnt == 2'b10, q[0].id);
                gnt_cyc  = cyc;
                clr_cyc  = -100;
                in_frame = 1;
                xs       = '0;
                clr_n    = 0;
            end
            if (!det_nRST) begin
                clr_n++;
                if (clr_n == 1) begin
                    chk("clr_after_gnt", cyc - gnt_cyc, 1);
                    clr_cyc = cyc;
                end
            end
            det_Y = 1'b0;
            if (in_frame && q.size() > 0) begin
                j = cyc - clr_cyc - 1;
                if (j >= 0 && j <= 7) xs = {xs[6:0], det_X};
                if (j >= 0 && j <= 8) det_Y = q[0].mask[j];
            end
            if (done) begin
                chk("det_X_zero_in_done", det_X, 0);
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    it = q.pop_front();
                    chk("done_id", done_id, it.id);
                    chk("hit_count", hit_count, it.hits);
                    chk("hit_count_cnt2", hit_count2, (it.hits > 3) ? 3 : it.hits);
                    chk("done_cnt2", done2, 1);
                    chk("det_X_seq", xs, it.data);
                    chk("latency_gnt_to_done", cyc - gnt_cyc, 11);
                    chk("clr_pulses", clr_n, 1);
                end
                in_frame = 0;
            end
        end
    end

    task automatic wait_gnt();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (gnt != 2'b00) seen = 1;
        end
        if (!seen) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (done) seen = 1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
    endtask

    task automatic do_frame(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                            input int id, input logic [7:0] xd, input logic [8:0] m,
                            input int h);
        item_t e;
        e.id = id; e.data = xd; e.mask = m; e.hits = h;
        q.push_back(e);
        data0 = d0;
        data1 = d1;
        req   = r;
        wait_gnt();
        // Frame data was latched at selection; disturb inputs to prove it
        req   = 2'b00;
        data0 = ~d0;
        data1 = ~d1;
        wait_done();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int  n;
        bit  seen;
        item_t e;
        nRST  = 1'b0;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_det_X", det_X, 0);
        chk("rst_det_nRST", det_nRST, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_hit_count", hit_count, 0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_det_nRST", det_nRST, 1);
        chk("idle_busy", busy, 0);

        // Single frames
        do_frame(2'b01, 8'b1011_0110, 8'h00, 0, 8'b1011_0110, 9'b0_0000_0000, 0);
        do_frame(2'b01, 8'b1011_0110, 8'h00, 0, 8'b1011_0110, 9'b0_0100_1000, 2);
        do_frame(2'b01, 8'b1011_0110, 8'h00, 0, 8'b1011_0110, 9'b1_1111_1110, 8);
        // Cycle 0 is not a sample; drain cycle is
        do_frame(2'b10, 8'hFF, 8'hC5, 1, 8'hC5, 9'b1_0000_0001, 1);

        // Contention: three frames with req=11 held
`ifdef SEQ_SCHED_RR_EN
        e.id = 0; e.data = 8'h3C; e.mask = 9'b0_0000_0110; e.hits = 2; q.push_back(e);
        e.id = 1; e.data = 8'hE1; q.push_back(e);
        e.id = 0; e.data = 8'h3C; q.push_back(e);
`else
        e.id = 0; e.data = 8'h3C; e.mask = 9'b0_0000_0110; e.hits = 2; q.push_back(e);
        q.push_back(e);
        q.push_back(e);
`endif
        data0 = 8'h3C;
        data1 = 8'hE1;
        req   = 2'b11;
        n = 0;
        for (int i = 0; i < 80 && n < 3; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                n++;
                if (n == 3) req = 2'b00;
            end
        end
        chk("contention_frames", n, 3);
        if (n != 3) q.delete();
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_after_contention", busy, 0);

        // Reset in SHIFT cycle 4
        e.id = 0; e.data = 8'hA5; e.mask = '0; e.hits = 0; q.push_back(e);
        data0 = 8'hA5;
        req   = 2'b01;
        wait_gnt();
        req = 2'b00;
        repeat (6) @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_det_X", det_X, 0);
        chk("abort_det_nRST", det_nRST, 0);
        chk("abort_done", done, 0);
        q.delete();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            if (done) seen = 1;
        end
        chk("no_done_after_abort", seen, 0);

        do_frame(2'b01, 8'h5A, 8'h00, 0, 8'h5A, 9'b0_1010_1010, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
